addn_serial: RTL and testbench

Parametrised digit-serial adder: the sequential successor to the 1-bit gate-level full adder. It adds two WIDTH-bit operands plus carry-in over WIDTH/DIGIT clock cycles, DIGIT bits per cycle, through a single reused DIGIT-bit ripple slice. It returns sum, carry-out and signed overflow behind valid/ready handshakes on both sides. It serves as the area-lean arithmetic unit in test benches and PLI-instrumented designs, where one adder is shared over time.

---
 rtl/addn_serial_pkg.sv | 18 +
 rtl/addn_digit.sv | 27 ++
 rtl/addn_serial.sv | 111 +++++++++++
 tb/tb_addn_serial.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/addn_serial_pkg.sv
// rtl/addn_serial_pkg.sv - shared types and sizing helpers for the digit-serial adder
package addn_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addn_digit.sv
// rtl/addn_digit.sv - combinational DIGIT-bit ripple slice built from full-adder cells
module addn_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    always_comb begin
        logic cy;
        cy    = ci;
        c_msb = ci;
        s     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            // c_msb is the carry entering the top bit of the slice
            if (i == DIGIT - 1) c_msb = cy;
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        co = cy;
    end

endmodule

// File: rtl/addn_serial.sv
// rtl/addn_serial.sv - digit-serial adder with valid/ready on operand and result sides
module addn_serial
    import addn_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CW    = cnt_w(STEPS);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("addn_serial: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;
    logic             ovf_q;

    logic [DIGIT-1:0] d_s;
    logic             d_co;
    logic             d_c_msb;
    logic [WIDTH-1:0] sum_next;
    logic             last;

    addn_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .ci    (carry),
        .s     (d_s),
        .co    (d_co),
        .c_msb (d_c_msb)
    );

    // New digit enters at the top so the LSB digit ends up at bit 0 after STEPS shifts
    assign sum_next = (sum_sh >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
    assign last     = (cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= ci;
                        cnt    <= '0;
                        sum_sh <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    sum_sh <= sum_next;
                    carry  <= d_co;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum_q <= sum_next;
                        co_q  <= d_co;
                        ovf_q <= d_co ^ d_c_msb;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with rst keeps in_ready low while reset holds the FSM in IDLE
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_addn_serial.sv
// tb/tb_addn_serial.sv - randomized self-checking bench over DIGIT = 1, 2, 4, 8
module tb_addn_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_v  [4];
    logic       in_ready_v  [4];
    logic [7:0] a_v         [4];
    logic [7:0] b_v         [4];
    logic       ci_v        [4];
    logic       out_valid_v [4];
    logic       out_ready_v [4];
    logic [7:0] sum_v       [4];
    logic       co_v        [4];
    logic       ovf_v       [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        addn_serial #(.WIDTH(8), .DIGIT(1 << g)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .ci        (ci_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .sum       (sum_v[g]),
            .co        (co_v[g]),
            .ovf       (ovf_v[g])
        );
    end

    // Reference: plain integer addition, overflow from operand/result sign rule
    function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv, input logic civ);
        logic [8:0] t;
        logic       o;
        t = {1'b0, av} + {1'b0, bv} + {8'd0, civ};
        o = (av[7] == bv[7]) && (t[7] != av[7]);
        return {o, t[8], t[7:0]};
    endfunction

    // Starts at posedge+1 with the instance idle; returns at posedge+1 after the output handshake
    task automatic do_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic civ,
                         output logic [7:0] s, output logic c, output logic o, output int lat);
        checks++;
        if (in_ready_v[k] !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_before_op k=%0d got %b want 1", k, in_ready_v[k]);
        end
        a_v[k] = av; b_v[k] = bv; ci_v[k] = civ; in_valid_v[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
        lat = 0;
        while (out_valid_v[k] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid_v[k] !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout k=%0d got %b want 1", k, out_valid_v[k]);
        end
        s = sum_v[k]; c = co_v[k]; o = ovf_v[k];
        out_ready_v[k] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[k] = 1'b0;
        checks++;
        if (in_ready_v[k] !== 1'b1 || out_valid_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake k=%0d got in_ready=%b out_valid=%b want 1/0",
                     k, in_ready_v[k], out_valid_v[k]);
        end
    endtask

    task automatic check_result(input string name, input int k, input logic [7:0] av, input logic [7:0] bv,
                                input logic civ, input logic [7:0] s, input logic c, input logic o, input int lat);
        logic [9:0] exp;
        exp = model(av, bv, civ);
        checks++;
        if ({o, c, s} !== exp) begin
            errors++;
            $display("FAIL %s k=%0d a=%h b=%h ci=%b got ovf=%b co=%b sum=%h want ovf=%b co=%b sum=%h",
                     name, k, av, bv, civ, o, c, s, exp[9], exp[8], exp[7:0]);
        end
        checks++;
        if (lat != (8 >> k)) begin
            errors++;
            $display("FAIL %s_latency k=%0d got %0d want %0d", name, k, lat, 8 >> k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
            a_v[k] = 8'h00; b_v[k] = 8'h00; ci_v[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({in_ready_v[k], out_valid_v[k], sum_v[k], co_v[k], ovf_v[k]} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got rdy=%b vld=%b sum=%h co=%b ovf=%b want all 0",
                         k, in_ready_v[k], out_valid_v[k], sum_v[k], co_v[k], ovf_v[k]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_ready_v[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_ready k=%0d got %b want 1", k, in_ready_v[k]);
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] s; logic c, o; int lat;
        do_op(0, 8'hFF, 8'h01, 1'b0, s, c, o, lat);
        check_result("d1_ff_01", 0, 8'hFF, 8'h01, 1'b0, s, c, o, lat);
        do_op(1, 8'h7F, 8'h01, 1'b0, s, c, o, lat);
        check_result("d2_7f_01", 1, 8'h7F, 8'h01, 1'b0, s, c, o, lat);
        do_op(1, 8'h80, 8'h80, 1'b0, s, c, o, lat);
        check_result("d2_80_80", 1, 8'h80, 8'h80, 1'b0, s, c, o, lat);
        do_op(3, 8'h12, 8'h34, 1'b1, s, c, o, lat);
        check_result("d8_12_34", 3, 8'h12, 8'h34, 1'b1, s, c, o, lat);
        checks++;
        if (s !== 8'h47) begin
            errors++;
            $display("FAIL d8_literal got %h want 47", s);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s0; logic c0, o0; int lat;
        a_v[0] = 8'hC3; b_v[0] = 8'h5A; ci_v[0] = 1'b1; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        s0 = sum_v[0]; c0 = co_v[0]; o0 = ovf_v[0];
        check_result("bp_result", 0, 8'hC3, 8'h5A, 1'b1, s0, c0, o0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || sum_v[0] !== s0 ||
                co_v[0] !== c0 || ovf_v[0] !== o0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b sum=%h co=%b want 1/0/%h/%b",
                         i, out_valid_v[0], in_ready_v[0], sum_v[0], co_v[0], s0, c0);
            end
        end
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        checks++;
        if (in_ready_v[0] !== 1'b1 || sum_v[0] !== s0) begin
            errors++;
            $display("FAIL bp_release got rdy=%b sum=%h want 1/%h", in_ready_v[0], sum_v[0], s0);
        end
    endtask

    task automatic test_ignored_inputs();
        int lat;
        a_v[1] = 8'h21; b_v[1] = 8'h13; ci_v[1] = 1'b0; in_valid_v[1] = 1'b1;
        @(posedge clk); #1;
        a_v[1] = 8'hFF; b_v[1] = 8'hFF; ci_v[1] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        lat = 1;
        while (out_valid_v[1] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check_result("ignored_inputs", 1, 8'h21, 8'h13, 1'b0, sum_v[1], co_v[1], ovf_v[1], lat);
        out_ready_v[1] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[1] = 1'b0;
    endtask

    task automatic test_mid_run_reset();
        logic [7:0] s; logic c, o; int lat;
        a_v[0] = 8'h33; b_v[0] = 8'h44; ci_v[0] = 1'b0; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready_v[0], out_valid_v[0], sum_v[0], co_v[0], ovf_v[0]} !== 12'h000) begin
            errors++;
            $display("FAIL midrun_reset got rdy=%b vld=%b sum=%h co=%b ovf=%b want all 0",
                     in_ready_v[0], out_valid_v[0], sum_v[0], co_v[0], ovf_v[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrun_release_ready got %b want 1", in_ready_v[0]);
        end
        do_op(0, 8'h0A, 8'h05, 1'b0, s, c, o, lat);
        check_result("post_reset_op", 0, 8'h0A, 8'h05, 1'b0, s, c, o, lat);
    endtask

    task automatic test_random();
        logic [7:0] av, bv, s; logic civ, c, o; int lat;
        for (int i = 0; i < 1000; i++) begin
            av  = 8'($urandom);
            bv  = 8'($urandom);
            civ = 1'($urandom);
            do_op(i % 4, av, bv, civ, s, c, o, lat);
            check_result("random", i % 4, av, bv, civ, s, c, o, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_ignored_inputs();
        test_mid_run_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
